// File: rtl/mage_pkg.sv
// Shared constants and types for the loop IV generator.
// The loop nest depth is the product of the subscript shape.
package mage_pkg;

  localparam int N_SUBSCRIPTS       = 2;
  localparam int N_IV_PER_SUBSCRIPT = 2;
  localparam int N_LP               = N_SUBSCRIPTS * N_IV_PER_SUBSCRIPT;
  localparam int NBIT_LP_IV         = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lp_state_e;

endpackage

// File: rtl/iv_counter.sv
// One loop level: holds its bounds/step and the current IV, advancing when
// every inner loop wraps (carry_i) and passing its own wrap outward.
module iv_counter
  import mage_pkg::*;
#(
  parameter int W = NBIT_LP_IV
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] lb_i,
  input  logic [W-1:0] ub_i,
  input  logic [W-1:0] step_i,
  input  logic         adv_i,
  input  logic         carry_i,
  output logic [W-1:0] iv_o,
  output logic         carry_o
);

  logic [W-1:0] lb_q, ub_q, step_q, iv_q;
  logic [W-1:0] iv_d;
  logic [W:0]   next_w;
  logic         wrap_w;

  // One extra bit so an IV close to the top of the range cannot alias below ub.
  assign next_w  = {1'b0, iv_q} + {1'b0, step_q};
  assign wrap_w  = (next_w >= {1'b0, ub_q});
  assign carry_o = carry_i & wrap_w;
  assign iv_o    = iv_q;

  always_comb begin
    iv_d = iv_q;
    if (load_i) begin
      iv_d = lb_i;
    end else if (adv_i && carry_i) begin
      iv_d = wrap_w ? lb_q : next_w[W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lb_q   <= '0;
      ub_q   <= '0;
      step_q <= '0;
      iv_q   <= '0;
    end else begin
      iv_q <= iv_d;
      if (load_i) begin
        lb_q   <= lb_i;
        ub_q   <= ub_i;
        // A zero step would never terminate; treat it as unit stride.
        step_q <= (step_i == '0) ? W'(1) : step_i;
      end
    end
  end

endmodule

// File: rtl/loop_iv_gen.sv
// Loop-nest induction variable generator: walks an N_LP-deep nest, one
// iteration per accepted beat, loop 0 innermost.
module loop_iv_gen
  import mage_pkg::*;
#(
  parameter int N_LP    = mage_pkg::N_LP,
  parameter int NBIT_IV = NBIT_LP_IV
) (
  input  logic                                                   clk_i,
  input  logic                                                   rst_n_i,
  input  logic                                                   start_i,
  input  logic                                                   abort_i,
  input  logic [N_LP-1:0][NBIT_IV-1:0]                           lb_i,
  input  logic [N_LP-1:0][NBIT_IV-1:0]                           ub_i,
  input  logic [N_LP-1:0][NBIT_IV-1:0]                           step_i,
  output logic [N_SUBSCRIPTS-1:0][N_IV_PER_SUBSCRIPT-1:0][NBIT_IV-1:0] iv_o,
  output logic                                                   valid_o,
  input  logic                                                   ready_i,
  output logic                                                   last_o,
  output logic                                                   busy_o,
  output logic                                                   done_o,
  output lp_state_e                                              state_o
);

  localparam int NSLOT = N_SUBSCRIPTS * N_IV_PER_SUBSCRIPT;

  // Handshake: a beat transfers on a rising edge where valid_o && ready_i and
  // abort_i is low; iv_o/last_o stay put while valid_o is high and ready_i low.

  lp_state_e state_q, state_d;

  logic [N_LP-1:0][NBIT_IV-1:0] iv_w;
  logic [N_LP:0]                carry_w;
  logic [NSLOT*NBIT_IV-1:0]     iv_flat_w;
  logic                         zero_trip_w;
  logic                         load_w;
  logic                         adv_w;
  logic                         last_all_w;
  logic                         run_w;

  assign run_w      = (state_q == ST_RUN);
  // The carry out of the outermost loop is set only when every loop wraps.
  assign last_all_w = carry_w[N_LP];
  assign load_w     = (state_q == ST_IDLE) && start_i && !abort_i;
  assign adv_w      = run_w && !abort_i && ready_i && !last_all_w;
  assign carry_w[0] = 1'b1;

  always_comb begin
    zero_trip_w = 1'b0;
    for (int k = 0; k < N_LP; k++) begin
      if (lb_i[k] >= ub_i[k]) zero_trip_w = 1'b1;
    end
  end

  for (genvar k = 0; k < N_LP; k++) begin : g_lp
    iv_counter #(.W(NBIT_IV)) u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (load_w),
      .lb_i    (lb_i[k]),
      .ub_i    (ub_i[k]),
      .step_i  (step_i[k]),
      .adv_i   (adv_w),
      .carry_i (carry_w[k]),
      .iv_o    (iv_w[k]),
      .carry_o (carry_w[k+1])
    );
  end

  always_comb begin
    iv_flat_w = '0;
    for (int k = 0; k < N_LP; k++) begin
      iv_flat_w[k*NBIT_IV +: NBIT_IV] = iv_w[k];
    end
  end

  assign iv_o    = iv_flat_w;
  assign valid_o = run_w;
  assign busy_o  = run_w;
  assign last_o  = run_w && last_all_w;
  assign done_o  = (state_q == ST_DONE);
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!abort_i && start_i) state_d = zero_trip_w ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (abort_i)                             state_d = ST_DONE;
        else if (ready_i && last_all_w)          state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

endmodule

// File: tb/tb_loop_iv_gen.sv
// Directed bench for loop_iv_gen: expected beats queued by the stimulus,
// checked by an independent monitor on the falling edge.
module tb_loop_iv_gen;
  import mage_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start_i = 1'b0, abort_i = 1'b0, ready_i = 1'b1;
  logic [3:0][W-1:0] lb_i = '0, ub_i = '0, step_i = '0;
  logic [1:0][1:0][W-1:0] iv_o;
  logic valid_o, last_o, busy_o, done_o;
  lp_state_e state_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4*W:0] exp_q[$];

  loop_iv_gen #(.NBIT_IV(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .abort_i(abort_i),
    .lb_i(lb_i), .ub_i(ub_i), .step_i(step_i), .iv_o(iv_o),
    .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int l0, input int l1, input int l2, input int l3, input bit lst);
    logic [4*W-1:0] iv;
    iv = {W'(l3), W'(l2), W'(l1), W'(l0)};
    exp_q.push_back({iv, lst});
  endtask

  task automatic set_cfg(input logic [3:0][W-1:0] lb, input logic [3:0][W-1:0] ub,
                         input logic [3:0][W-1:0] st);
    lb_i = lb; ub_i = ub; step_i = st;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  // Runs until the final beat is accepted, then checks the done pulse timing
  // and that a start coinciding with done_o is ignored.
  task automatic run_to_end(input string name, input bit toggle);
    bit found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (valid_o && ready_i && last_o) found = 1'b1;
      else begin
        @(posedge clk); #1;
        if (toggle) ready_i = ~ready_i;
      end
    end
    check({name, "_last_seen"}, 64'(found), 64'd1);
    @(posedge clk); #1 ready_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    check({name, "_done_pulse"}, 64'({done_o, valid_o, busy_o}), 64'b100);
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    check({name, "_done_clear"}, 64'({done_o, valid_o}), 64'b00);
    check({name, "_start_in_done_ignored"}, 64'(state_o), 64'(ST_IDLE));
  endtask

  task automatic push_basic();
    push_beat(0, 0, 0, 0, 0); push_beat(1, 0, 0, 0, 0);
    push_beat(0, 1, 0, 0, 0); push_beat(1, 1, 0, 0, 0);
    push_beat(0, 2, 0, 0, 0); push_beat(1, 2, 0, 0, 1);
  endtask

  // Monitor: pops on every accepted beat and verifies stall stability.
  logic           stall_q = 1'b0;
  logic [4*W:0]   stall_v;
  always @(negedge clk) begin
    logic [4*W:0] act, exp;
    act = {iv_o, last_o};
    if (stall_q && valid_o) begin
      n_tests++;
      if (act !== stall_v) begin
        n_fail++;
        $display("FAIL stall_hold: got %0h expected %0h", act, stall_v);
      end
    end
    stall_q = valid_o && !ready_i && rst_n;
    stall_v = act;
    if (rst_n && valid_o && ready_i && !abort_i) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got %0h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL beat: got %0h expected %0h", act, exp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    #23 rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", 64'({valid_o, last_o, busy_o, done_o}), 64'd0);
    check("reset_iv", 64'(iv_o), 64'd0);
    check("reset_state", 64'(state_o), 64'(ST_IDLE));

    // Basic 2x3 nest, full throughput.
    set_cfg({8'd0, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd1, 8'd3, 8'd2}, {8'd1, 8'd1, 8'd1, 8'd1});
    push_basic();
    pulse_start();
    run_to_end("basic", 1'b0);
    check("basic_queue_empty", 64'(exp_q.size()), 64'd0);

    // Same nest with back-pressure.
    push_basic();
    pulse_start();
    run_to_end("stall", 1'b1);
    check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Zero-trip: done one cycle after start, no beats.
    set_cfg({8'd0, 8'd0, 8'd0, 8'd5}, {8'd1, 8'd1, 8'd1, 8'd5}, {8'd1, 8'd1, 8'd1, 8'd1});
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    check("zero_trip_done", 64'({done_o, valid_o}), 64'b10);
    @(negedge clk);
    check("zero_trip_idle", 64'({done_o, valid_o, state_o}), 64'({2'b00, ST_IDLE}));

    // Near-overflow stride: 250, 254 then finish.
    set_cfg({8'd0, 8'd0, 8'd0, 8'd250}, {8'd1, 8'd1, 8'd1, 8'd255}, {8'd1, 8'd1, 8'd1, 8'd4});
    push_beat(250, 0, 0, 0, 0); push_beat(254, 0, 0, 0, 1);
    pulse_start();
    run_to_end("ovf", 1'b0);

    // Zero step behaves as unit step.
    set_cfg({8'd0, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd1, 8'd1, 8'd3}, {8'd0, 8'd0, 8'd0, 8'd0});
    push_beat(0, 0, 0, 0, 0); push_beat(1, 0, 0, 0, 0); push_beat(2, 0, 0, 0, 1);
    pulse_start();
    run_to_end("step0", 1'b0);

    // Abort on beat 3, with a start in RUN that must be ignored.
    set_cfg({8'd0, 8'd0, 8'd0, 8'd0}, {8'd1, 8'd1, 8'd3, 8'd2}, {8'd1, 8'd1, 8'd1, 8'd1});
    push_beat(0, 0, 0, 0, 0); push_beat(1, 0, 0, 0, 0);
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1 abort_i = 1'b1; start_i = 1'b1;
    @(negedge clk);
    check("abort_beat3_iv", 64'(iv_o), 64'h0000_0100);
    @(posedge clk); #1 abort_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("abort_done", 64'({done_o, valid_o, busy_o}), 64'b100);
    @(negedge clk);
    check("abort_idle", 64'({done_o, valid_o, state_o}), 64'({2'b00, ST_IDLE}));
    check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

    // Abort in IDLE: nothing happens.
    @(posedge clk); #1 abort_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1 abort_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("abort_idle_nodone", 64'({done_o, valid_o, state_o}), 64'({2'b00, ST_IDLE}));

    // Reset mid-run, then a normal nest.
    push_beat(0, 0, 0, 0, 0); push_beat(1, 0, 0, 0, 0);
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 64'({valid_o, last_o, busy_o, done_o}), 64'd0);
    check("rst_async_iv", 64'(iv_o), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    begin
      bit saw_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (done_o || valid_o) saw_done = 1'b1;
      end
      check("rst_no_done", 64'(saw_done), 64'd0);
    end
    check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
    push_basic();
    pulse_start();
    run_to_end("post_rst", 1'b0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_iv_gen.md
LOOP_IV_GEN -- requirements
Module: loop_iv_gen

Interface
REQ-001 SHALL have parameter N_LP, default N_SUBSCRIPTS*N_IV_PER_SUBSCRIPT (4), meaning loop nest depth.
REQ-002 SHALL have parameter NBIT_IV, default NBIT_LP_IV, meaning IV/bound/step width.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle pulse; captures config, begins nest.
REQ-006 SHALL have port abort_i  input  1  terminates the nest immediately.
REQ-007 SHALL have port lb_i  input  N_LP x NBIT_IV  per-loop lower bound (first IV value).
REQ-008 SHALL have port ub_i  input  N_LP x NBIT_IV  per-loop exclusive upper bound.
REQ-009 SHALL have port step_i  input  N_LP x NBIT_IV  per-loop increment.
REQ-010 SHALL have port iv_o  output  N_SUBSCRIPTS x N_IV_PER_SUBSCRIPT x NBIT_IV  current IVs; loop k at [k/N_IV_PER_SUBSCRIPT][k%N_IV_PER_SUBSCRIPT].
REQ-011 SHALL have port valid_o  output  1  iv_o holds a valid iteration.
REQ-012 SHALL have port ready_i  input  1  consumer (subscript/address path) accepts iv_o.
REQ-013 SHALL have port last_o  output  1  qualifies valid_o: final iteration of the nest.
REQ-014 SHALL have port busy_o  output  1  high in RUN.
REQ-015 SHALL have port done_o  output  1  one-cycle pulse on nest completion or abort.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 IDLE and start_i: SHALL register lb/ub/step (step 0 stored as 1), load iv[k]=lb[k], go RUN next cycle.
REQ-018 IDLE and start_i with any lb[k]>=ub[k] (unsigned): SHALL go to DONE without asserting valid_o (zero-trip).
REQ-019 valid_o SHALL equal (state==RUN); iv_o SHALL be driven directly from registers.
REQ-020 iv_o and last_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-021 On valid_o&&ready_i SHALL advance one iteration in one cycle (throughput 1 per cycle).
REQ-022 Loop 0 innermost, loop N_LP-1 outermost; advance SHALL compute next = iv[k]+step[k] in NBIT_IV+1 bits, no wrap-around aliasing.
REQ-023 Loop k SHALL increment only if all inner loops wrap; if next>=ub[k] it SHALL reload lb[k] and carry outward, else take next.
REQ-024 last_o SHALL be high iff every loop satisfies iv[k]+step[k]>=ub[k].
REQ-025 Handshake with last_o=1 SHALL move RUN->DONE; IVs hold their final values.
REQ-026 abort_i SHALL take priority over handshake and start_i: RUN->DONE, IDLE stays IDLE (no done_o).
REQ-027 start_i outside IDLE SHALL be ignored; config inputs SHALL be sampled only at accepted start.
REQ-028 Simultaneous done_o and start_i SHALL ignore start_i.

Reset
REQ-029 rst_n_i low SHALL asynchronously force IDLE, all IV/config registers 0, valid_o=0, last_o=0, busy_o=0, done_o=0.
REQ-030 Reset mid-RUN SHALL discard the nest; no done_o after release; next start_i processed normally.

Structure
REQ-031 FSM state enum type and N_LP constant SHALL live in mage_pkg; N_SUBSCRIPTS, N_IV_PER_SUBSCRIPT, NBIT_LP_IV reused from it.
REQ-032 Per-loop increment/wrap/carry SHALL be one sub-module, iv_counter, instantiated N_LP times in a carry chain.
REQ-033 Target size 150-300 RTL lines; no multipliers.

Verification
REQ-034 lb={0,0,0,0}, ub={2,3,1,1}, step=1, ready_i=1 -> 6 valid beats, loop0 0,1,0,1,0,1 / loop1 0,0,1,1,2,2, last_o on beat 6, done_o one cycle later.
REQ-035 Same config, ready_i toggled 1/0 -> iv_o stable during stalls, identical 6-beat sequence.
REQ-036 lb[0]=5, ub[0]=5 -> no valid_o, done_o 1 cycle after start_i.
REQ-037 NBIT_IV=8, lb[0]=250, ub[0]=255, step[0]=4, others 0/1/1 -> loop0 beats 250,254 then last; no overflow wrap.
REQ-038 abort_i on beat 3 with ready_i=1 -> valid_o low next cycle, done_o pulse, busy_o low; start_i in RUN ignored.
REQ-039 rst_n_i low mid-RUN -> outputs 0 asynchronously, no done_o after release.
